dual_ram_tdp: RTL and testbench
===============================

# dual_ram_tdp

True dual-port synchronous RAM: the parametrised successor to the single-write dual-read RAM. Two independent ports A and B can each read or write in any cycle. Read data is registered. Read-during-write behaviour is selectable, and same-address collisions are resolved and flagged. After every reset, an internal sweep FSM loads the power-on pattern (address+1), so contents are defined without simulation-only initialisation. It sits between two masters, e.g. CPU and DMA, that share one buffer.

## Interface
- N, 32, number of words (≥2)
- B, 8, word width in bits
- Add, $clog2(N), address width
- RDW_MODE, 0, read-during-write result: 0 = old data (read-first), 1 = new data (write-first)
- clk  input  1  clock, all state changes on rising edge
- rst  input  1  reset; asynchronous, active-high
- en_a / en_b  input  1  port request enable
- wr_a / wr_b  input  1  write when en=1; read when wr=0
- addrLine_a / addrLine_b  input  Add  word address; values ≥N are ignored (no write, read returns 0)
- dataIn_a / dataIn_b  input  B  write data
- dataOut_a / dataOut_b  output  B  registered read data
- valid_a / valid_b  output  1  dataOut updated this cycle (1-cycle pulse)
- ready  output  1  initialisation sweep complete; requests are accepted only when 1
- collision  output  1  1-cycle pulse: both ports hit the same address last cycle with ≥1 write

## Operation
- FSM states: INIT, RUN.
- rst=1 (any time, including mid-sweep or mid-access): state←INIT, sweep counter←0. All outputs are 0: ready, valid_a/b, collision, and dataOut_a/b=0. Memory is not otherwise cleared asynchronously.
- INIT: each clock writes mem[cnt]←(cnt+1) truncated to B bits, then cnt++. The sweep runs while rst=0. The write at cnt=N-1 moves the FSM to RUN, with ready=1 from that edge onward. Requests during INIT are ignored: no write, valid=0.
- RUN: RUN is held until the next reset. Each port is evaluated independently per clock:
  - en=0: no access; valid=0; dataOut holds its previous value.
  - en=1, wr=0: dataOut←mem[addr]; valid=1.
  - en=1, wr=1: mem[addr]←dataIn; valid=1. dataOut takes the old word (RDW_MODE=0) or dataIn (RDW_MODE=1).
- Collision (en_a & en_b, addrLine_a==addrLine_b, wr_a|wr_b):
  - Both write: port A wins. Port B's write is dropped. Each port's dataOut follows its own RDW_MODE rule, and in mode 1 the B port sees dataIn_a (the stored value).
  - One writes, one reads: the reader gets old data (RDW_MODE=0) or the writer's dataIn (RDW_MODE=1).
  - Both read: normal read, no collision flag.
  - collision=1 on the same edge the affected valids rise.
- An out-of-range address (≥N, possible when N is not a power of 2) never alters memory, returns dataOut=0 with valid=1, and never flags a collision.

## Timing
- Read/write latency: a request sampled at rising edge k gives dataOut/valid/collision visible after edge k, for one cycle. Write data is readable by the other port from edge k+1.
- Init: after rst falls, ready rises on the N-th rising edge. The first request is accepted on the edge after ready is seen high.
- Back-to-back requests every cycle on both ports sustain full throughput: no stalls, no handshake back-pressure.
- valid_a and valid_b are registered copies of (en & ready), so they are never combinational from the inputs.
- Asynchronous rst takes effect without a clock edge. Deassertion is assumed synchronised upstream.

## Test plan
- Reset/init: pulse rst, release, then hold all enables at 0. Required: ready=0 for 32 cycles, then 1. Reading A addresses 0..31 returns 1..32 with valid_a=1 one cycle after each request.
- Independent traffic: on one edge, A writes 8'hAA to address 5 and B reads address 9. Required next cycle: dataOut_b=10, valid_a=valid_b=1, collision=0. B then reads 5 and gets 8'hAA.
- Read-during-write, both modes: A writes 8'h55 to address 3, which holds 4, while B reads address 3. Required: dataOut_b=4 with RDW_MODE=0, 8'h55 with RDW_MODE=1. collision=1 for exactly 1 cycle.
- Write/write collision: A writes 8'h11 and B writes 8'h22 to address 7 in the same cycle. Required: collision=1, and a later read of 7 from either port returns 8'h11.
- Reset mid-operation: assert rst during INIT (cnt≈10) and again during RUN after writing 8'hFF to address 0. Required: outputs go 0 immediately, the sweep restarts from 0, ready rises 32 edges after release, and address 0 reads 1.
- Out-of-range and idle: with N=20, a write to address 25 followed by a sweep read of all 20 words shows no change. A read of address 25 gives dataOut=0, valid=1. When en=0, the previous dataOut is held and valid=0.

Source files
------------

// File: rtl/dual_ram_tdp.sv
// dual_ram_tdp: true dual-port RAM, registered reads, selectable read-during-write,
// A-wins collisions, post-reset sweep loading mem[i]=i+1.
// Ports: clk, rst (async high); per port en/wr/addrLine/dataIn in,
// dataOut/valid out; ready (sweep done), collision (same-address pulse).
module dual_ram_tdp #(
  parameter int N        = 32,
  parameter int B        = 8,
  parameter int Add      = $clog2(N),
  parameter int RDW_MODE = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en_a,
  input  logic           en_b,
  input  logic           wr_a,
  input  logic           wr_b,
  input  logic [Add-1:0] addrLine_a,
  input  logic [Add-1:0] addrLine_b,
  input  logic [B-1:0]   dataIn_a,
  input  logic [B-1:0]   dataIn_b,
  output logic [B-1:0]   dataOut_a,
  output logic [B-1:0]   dataOut_b,
  output logic           valid_a,
  output logic           valid_b,
  output logic           ready,
  output logic           collision
);

  typedef enum logic {INIT, RUN} state_t;

  state_t         state, stateNext;
  logic [Add-1:0] cnt, cntNext;
  logic           sweepWe;
  logic [B-1:0]   mem [N];

  logic         run, fwd;
  logic         inA, inB, hit;
  logic         weA, weB;
  logic [B-1:0] rdA, rdB;
  logic [B-1:0] nextA, nextB;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    sweepWe   = 1'b0;
    unique case (state)
      INIT: begin
        sweepWe = 1'b1;
        cntNext = cnt + Add'(1);
        if (int'(cnt) == N - 1) begin
          stateNext = RUN;
          cntNext   = '0;
        end
      end
      RUN: ;
    endcase
  end

  assign run   = (state == RUN);
  assign ready = run;
  assign fwd   = (RDW_MODE == 1);

  assign inA = (int'(addrLine_a) < N);
  assign inB = (int'(addrLine_b) < N);
  // both enabled on one in-range word
  assign hit = en_a & en_b & inA & (addrLine_a == addrLine_b);

  assign weA = run & en_a & wr_a & inA;
  // port B's write is dropped when A writes the same word
  assign weB = run & en_b & wr_b & inB & ~(hit & wr_a);

  assign rdA = inA ? mem[addrLine_a] : '0;
  assign rdB = inB ? mem[addrLine_b] : '0;

  always_comb begin
    nextA = rdA;
    if (!inA)
      nextA = '0;
    else if (wr_a)
      nextA = fwd ? dataIn_a : rdA;
    else if (hit & wr_b & fwd)
      nextA = dataIn_b;
  end

  always_comb begin
    nextB = rdB;
    if (!inB)
      nextB = '0;
    else if (wr_b)
      nextB = fwd ? ((hit & wr_a) ? dataIn_a : dataIn_b) : rdB;
    else if (hit & wr_a & fwd)
      nextB = dataIn_a;
  end

  // While rst is held the sweep may refresh mem[0] with its own pattern;
  // the sweep after release rewrites it anyway.
  always_ff @(posedge clk) begin
    if (sweepWe) begin
      mem[cnt] <= B'(int'(cnt) + 1);
    end else begin
      if (weA) mem[addrLine_a] <= dataIn_a;
      if (weB) mem[addrLine_b] <= dataIn_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dataOut_a <= '0;
      dataOut_b <= '0;
      valid_a   <= 1'b0;
      valid_b   <= 1'b0;
      collision <= 1'b0;
    end else begin
      valid_a   <= run & en_a;
      valid_b   <= run & en_b;
      collision <= run & hit & (wr_a | wr_b);
      if (run & en_a) dataOut_a <= nextA;
      if (run & en_b) dataOut_b <= nextB;
    end
  end

endmodule

// File: tb/tb_dual_ram_tdp.sv
// tb_dual_ram_tdp: three dual_ram_tdp instances (N=32 read-first, N=32 write-first,
// N=20 read-first) driven by shared stimulus, checked against a reference model.
module tb_dual_ram_tdp;

  localparam int NI = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en_a, en_b, wr_a, wr_b;
  logic [4:0] addrA, addrB;
  logic [7:0] dinA, dinB;

  logic [7:0] oA [NI];
  logic [7:0] oB [NI];
  logic       vA [NI];
  logic       vB [NI];
  logic       rdy [NI];
  logic       col [NI];

  logic [7:0] mm [NI][32];
  logic [7:0] eA [NI];
  logic [7:0] eB [NI];
  logic       eVa [NI];
  logic       eVb [NI];
  logic       eCol [NI];
  logic       rdyM [NI];
  int         edges [NI];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    dual_ram_tdp #(
      .N(g == 2 ? 20 : 32),
      .B(8),
      .RDW_MODE(g == 1 ? 1 : 0)
    ) u (
      .clk(clk),
      .rst(rst),
      .en_a(en_a),
      .en_b(en_b),
      .wr_a(wr_a),
      .wr_b(wr_b),
      .addrLine_a(addrA),
      .addrLine_b(addrB),
      .dataIn_a(dinA),
      .dataIn_b(dinB),
      .dataOut_a(oA[g]),
      .dataOut_b(oB[g]),
      .valid_a(vA[g]),
      .valid_b(vB[g]),
      .ready(rdy[g]),
      .collision(col[g])
    );
  end

  function automatic int nOf(int i);
    return (i == 2) ? 20 : 32;
  endfunction

  function automatic bit mdOf(int i);
    return (i == 1);
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic compareAll(string ctx);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("%s[%0d] dataOut_a", ctx, i), 32'(oA[i]), 32'(eA[i]));
      check($sformatf("%s[%0d] dataOut_b", ctx, i), 32'(oB[i]), 32'(eB[i]));
      check($sformatf("%s[%0d] valid_a", ctx, i), 32'(vA[i]), 32'(eVa[i]));
      check($sformatf("%s[%0d] valid_b", ctx, i), 32'(vB[i]), 32'(eVb[i]));
      check($sformatf("%s[%0d] ready", ctx, i), 32'(rdy[i]), 32'(rdyM[i]));
      check($sformatf("%s[%0d] collision", ctx, i), 32'(col[i]), 32'(eCol[i]));
    end
  endtask

  // Reference behaviour for one rising edge, using the inputs applied before it.
  task automatic modelEdge();
    for (int i = 0; i < NI; i++) begin
      int n;
      bit md, inA, inB, same, aW, bW;
      n  = nOf(i);
      md = mdOf(i);
      if (!rdyM[i]) begin
        edges[i]++;
        eVa[i]  = 1'b0;
        eVb[i]  = 1'b0;
        eCol[i] = 1'b0;
        if (edges[i] == n) begin
          rdyM[i] = 1'b1;
          for (int k = 0; k < n; k++) mm[i][k] = 8'(k + 1);
        end
      end else begin
        inA  = (int'(addrA) < n);
        inB  = (int'(addrB) < n);
        same = (addrA == addrB);
        aW   = en_a && wr_a;
        bW   = en_b && wr_b;
        if (en_a) begin
          if (!inA) eA[i] = 8'h00;
          else if (aW) eA[i] = md ? dinA : mm[i][addrA];
          else if (bW && same && md) eA[i] = dinB;
          else eA[i] = mm[i][addrA];
        end
        if (en_b) begin
          if (!inB) eB[i] = 8'h00;
          else if (bW) eB[i] = md ? ((aW && same) ? dinA : dinB) : mm[i][addrB];
          else if (aW && same && md) eB[i] = dinA;
          else eB[i] = mm[i][addrB];
        end
        eVa[i]  = en_a;
        eVb[i]  = en_b;
        eCol[i] = en_a && en_b && same && inA && (wr_a || wr_b);
        if (bW && inB) mm[i][addrB] = dinB;
        if (aW && inA) mm[i][addrA] = dinA;
      end
    end
  endtask

  task automatic cyc(input logic ea, input logic wa, input logic [4:0] aa,
                     input logic [7:0] da, input logic eb, input logic wb,
                     input logic [4:0] ab, input logic [7:0] db, input string tag);
    en_a  = ea;
    wr_a  = wa;
    addrA = aa;
    dinA  = da;
    en_b  = eb;
    wr_b  = wb;
    addrB = ab;
    dinB  = db;
    @(posedge clk);
    #1;
    modelEdge();
    compareAll(tag);
  endtask

  task automatic idle(int cycles, string tag);
    for (int c = 0; c < cycles; c++)
      cyc(1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00, tag);
  endtask

  task automatic doReset(string tag);
    en_a = 1'b0;
    en_b = 1'b0;
    wr_a = 1'b0;
    wr_b = 1'b0;
    rst  = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      eA[i]    = 8'h00;
      eB[i]    = 8'h00;
      eVa[i]   = 1'b0;
      eVb[i]   = 1'b0;
      eCol[i]  = 1'b0;
      rdyM[i]  = 1'b0;
      edges[i] = 0;
    end
    compareAll(tag);
    repeat (2) @(posedge clk);
    #1;
    compareAll({tag, "Hold"});
    rst = 1'b0;
  endtask

  initial begin
    en_a  = 1'b0;
    en_b  = 1'b0;
    wr_a  = 1'b0;
    wr_b  = 1'b0;
    addrA = '0;
    addrB = '0;
    dinA  = '0;
    dinB  = '0;

    doReset("rst");
    idle(33, "init");
    for (int a = 0; a < 32; a++)
      cyc(1'b1, 1'b0, 5'(a), 8'h00, 1'b0, 1'b0, 5'd0, 8'h00, "sweepRd");

    cyc(1'b1, 1'b1, 5'd5, 8'hAA, 1'b1, 1'b0, 5'd9, 8'h00, "indep");
    cyc(1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 1'b0, 5'd5, 8'h00, "rdBack");

    cyc(1'b1, 1'b1, 5'd3, 8'h55, 1'b1, 1'b0, 5'd3, 8'h00, "rdw");
    idle(1, "rdwAfter");

    cyc(1'b1, 1'b1, 5'd7, 8'h11, 1'b1, 1'b1, 5'd7, 8'h22, "wrwr");
    cyc(1'b1, 1'b0, 5'd7, 8'h00, 1'b1, 1'b0, 5'd7, 8'h00, "wrwrRd");

    cyc(1'b1, 1'b1, 5'd25, 8'h77, 1'b1, 1'b1, 5'd25, 8'h66, "oorWr");
    cyc(1'b1, 1'b0, 5'd25, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00, "oorRd");
    idle(2, "hold");
    for (int a = 0; a < 32; a++)
      cyc(1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 1'b0, 5'(a), 8'h00, "sweepRdB");

    cyc(1'b1, 1'b1, 5'd0, 8'hFF, 1'b0, 1'b0, 5'd0, 8'h00, "wrFF");
    doReset("rstRun");
    idle(10, "initPart");
    doReset("rstInit");
    idle(33, "reinit");
    cyc(1'b1, 1'b0, 5'd0, 8'h00, 1'b1, 1'b0, 5'd0, 8'h00, "rd0");

    for (int c = 0; c < 400; c++) begin
      logic [4:0] ra, rb;
      ra = 5'($urandom_range(0, 31));
      rb = ($urandom_range(0, 2) == 0) ? ra : 5'($urandom_range(0, 31));
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom), ra, 8'($urandom),
          1'($urandom_range(0, 3) != 0), 1'($urandom), rb, 8'($urandom),
          "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
